patt_scan_ctrl: RTL

- Sequencer around a programmable serial pattern detector: accepts a parallel data word on a start handshake and serializes it MSB-first into a PAT_W-bit sliding window.
- Compares the window against a configured pattern every bit; counts overlapping matches and records the first match position.
- Signals completion with a one-cycle done pulse.
- Sits between a word-oriented producer and the lab's bit-serial detector datapath, owning its configuration and sequencing.

---
 rtl/patt_scan_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/patt_scan_ctrl.sv
// Sequencer that shifts a parallel word MSB-first through a PAT_W-bit window and
// counts overlapping pattern matches. Optional `PATT_SCAN_ABORT_EN adds an abort input.
//
// state | meaning
// IDLE  | waiting for start; pattern writable
// SHIFT | one data bit per cycle enters the window and is compared
// DONE  | one-cycle completion pulse; pattern writable
module patt_scan_ctrl #(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(4'b1011)
) (
    input  logic              clk,
    input  logic              rst_b,
`ifdef PATT_SCAN_ABORT_EN
    input  logic              abort,
`endif
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              match_o,
    output logic              found,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  first_pos
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PAT_W-1:0]   pat;
    logic [DATA_W-1:0]  sreg;
    logic [PAT_W-1:0]   window;
    logic [CNT_W-1:0]   idx;
    logic [PAT_W-1:0]   win_nxt;
    logic               hit;
    logic               last_bit;
    logic               abort_hit;

`ifdef PATT_SCAN_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign win_nxt  = {window[PAT_W-2:0], sreg[DATA_W-1]};
    // Index gate keeps the zero-cleared window from producing partial-window hits.
    assign hit      = (idx >= CNT_W'(PAT_W - 1)) && (win_nxt == pat);
    assign last_bit = (idx == CNT_W'(DATA_W - 1));

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_hit) begin
                    state_nxt = IDLE;
                end else if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pat       <= PAT_INIT;
            sreg      <= '0;
            window    <= '0;
            idx       <= '0;
            match_o   <= 1'b0;
            found     <= 1'b0;
            match_cnt <= '0;
            first_pos <= '0;
        end else begin
            case (state)
                IDLE: begin
                    match_o <= 1'b0;
                    if (cfg_we) begin
                        pat <= cfg_pat;
                    end
                    if (start) begin
                        sreg      <= data;
                        window    <= '0;
                        idx       <= '0;
                        found     <= 1'b0;
                        match_cnt <= '0;
                        first_pos <= '0;
                    end
                end
                SHIFT: begin
                    if (abort_hit) begin
                        match_o   <= 1'b0;
                        found     <= 1'b0;
                        match_cnt <= '0;
                        first_pos <= '0;
                    end else begin
                        sreg    <= {sreg[DATA_W-2:0], 1'b0};
                        window  <= win_nxt;
                        idx     <= idx + CNT_W'(1);
                        match_o <= hit;
                        if (hit) begin
                            if (match_cnt != '1) begin
                                match_cnt <= match_cnt + CNT_W'(1);
                            end
                            if (!found) begin
                                found     <= 1'b1;
                                first_pos <= idx;
                            end
                        end
                    end
                end
                DONE: begin
                    match_o <= 1'b0;
                    if (cfg_we) begin
                        pat <= cfg_pat;
                    end
                end
                default: begin
                    match_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
